// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline control blocks.
package mips_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        MDWAIT = 2'd1
    } hz_state_t;

    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam int         STALL_CNT_W = 16;

    function automatic logic [STALL_CNT_W-1:0] sat_inc(
        input logic [STALL_CNT_W-1:0] v
    );
        return (v == '1) ? v : v + STALL_CNT_W'(1);
    endfunction

endpackage

// File: rtl/hazard_md_timer.sv
// Multiply/divide occupancy timer: busy for MD_LATENCY cycles after start.
module hazard_md_timer #(
    parameter int MD_LATENCY = 32,
    parameter int CW         = $clog2(MD_LATENCY + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          active_q, active_d;

    // A start while already active is ignored.
    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        if (active_q) begin
            if (cnt_q == '0) begin
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end else if (start) begin
            active_d = 1'b1;
            cnt_d    = CW'(MD_LATENCY - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign busy = active_q;
    assign done = active_q && (cnt_q == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use stalls, branch flushes, mult/div busy window
// and a saturating bubble counter.
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int MD_LATENCY = 32,
    parameter int CW         = $clog2(MD_LATENCY + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             IfIdRs,
    input  logic [4:0]             IfIdRt,
    input  logic                   IfIdUsesRt,
    input  logic                   IfIdIsMd,
    input  logic                   IdExMemRead,
    input  logic [4:0]             IdExRt,
    input  logic                   BranchTaken,
    input  logic                   MdStart,
    output logic                   PcWrite,
    output logic                   IfIdWrite,
    output logic                   IdExBubble,
    output logic                   IfIdFlush,
    output logic                   MdBusy,
    output logic [1:0]             State,
    output logic [STALL_CNT_W-1:0] StallCnt
);

    hz_state_t               state_q, state_d;
    logic [STALL_CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic                    md_start;
    logic                    md_busy;
    logic                    md_done;
    logic                    load_use;
    logic                    md_hold;
    logic                    stall;

    assign md_start = (state_q == RUN) && MdStart;

    hazard_md_timer #(
        .MD_LATENCY (MD_LATENCY),
        .CW         (CW)
    ) u_md_timer (
        .clk   (clk),
        .rst   (rst),
        .start (md_start),
        .busy  (md_busy),
        .done  (md_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (MdStart) begin
                    state_d = MDWAIT;
                end
            end
            MDWAIT: begin
                if (md_done) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        load_use = IdExMemRead && (IdExRt != REG_ZERO) &&
                   ((IdExRt == IfIdRs) ||
                    (IfIdUsesRt && (IdExRt == IfIdRt)));
        md_hold  = (state_q == MDWAIT) && IfIdIsMd;
        stall    = load_use || md_hold;
    end

    // A stall outranks a taken branch; the branch re-resolves later.
    always_comb begin
        PcWrite    = 1'b1;
        IfIdWrite  = 1'b1;
        IdExBubble = 1'b0;
        IfIdFlush  = 1'b0;
        MdBusy     = md_busy;
        if (rst) begin
            PcWrite    = 1'b0;
            IfIdWrite  = 1'b0;
            IdExBubble = 1'b1;
            IfIdFlush  = 1'b1;
            MdBusy     = 1'b0;
        end else if (stall) begin
            PcWrite    = 1'b0;
            IfIdWrite  = 1'b0;
            IdExBubble = 1'b1;
        end else if (BranchTaken) begin
            IfIdFlush  = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (IdExBubble && !rst) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign State    = state_q;
    assign StallCnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl at MD_LATENCY=4 and MD_LATENCY=1.
module tb_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       usesrt;
        logic       ismd;
        logic       memread;
        logic [4:0] exrt;
        logic       br;
        logic       mdst;
    } stim_t;

    localparam stim_t IDLE = '0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [4:0] if_rs = '0, if_rt = '0, ex_rt = '0;
    logic       uses_rt = 1'b0, is_md = 1'b0, mem_rd = 1'b0;
    logic       br_tk = 1'b0, md_st = 1'b0;

    logic        pc0, ifw0, bub0, fl0, busy0;
    logic        pc1, ifw1, bub1, fl1, busy1;
    logic [1:0]  st0, st1;
    logic [15:0] cnt0, cnt1;

    hazard_ctrl #(.MD_LATENCY(4)) u_dut4 (
        .clk(clk), .rst(rst), .IfIdRs(if_rs), .IfIdRt(if_rt),
        .IfIdUsesRt(uses_rt), .IfIdIsMd(is_md), .IdExMemRead(mem_rd),
        .IdExRt(ex_rt), .BranchTaken(br_tk), .MdStart(md_st),
        .PcWrite(pc0), .IfIdWrite(ifw0), .IdExBubble(bub0),
        .IfIdFlush(fl0), .MdBusy(busy0), .State(st0), .StallCnt(cnt0)
    );

    hazard_ctrl #(.MD_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .IfIdRs(if_rs), .IfIdRt(if_rt),
        .IfIdUsesRt(uses_rt), .IfIdIsMd(is_md), .IdExMemRead(mem_rd),
        .IdExRt(ex_rt), .BranchTaken(br_tk), .MdStart(md_st),
        .PcWrite(pc1), .IfIdWrite(ifw1), .IdExBubble(bub1),
        .IfIdFlush(fl1), .MdBusy(busy1), .State(st1), .StallCnt(cnt1)
    );

    // Reference model: remaining busy cycles and bubble count per instance.
    int lat[2] = '{4, 1};
    int md_left[2] = '{0, 0};
    int scnt[2] = '{0, 0};

    logic [22:0] expq0[$];
    logic [22:0] expq1[$];
    int errors = 0;
    int checks = 0;

    // Packed as {PcWrite, IfIdWrite, IdExBubble, IfIdFlush, MdBusy, State, StallCnt}
    function automatic logic [22:0] expect_out(int k, stim_t s);
        logic       lu, stall, b;
        logic [3:0] c;
        lu = s.memread && (s.exrt != 5'd0) &&
             ((s.exrt == s.rs) || (s.usesrt && (s.exrt == s.rt)));
        b = (md_left[k] > 0);
        stall = lu || (b && s.ismd);
        if (s.rst)        c = 4'b0011;
        else if (stall)   c = 4'b0010;
        else if (s.br)    c = 4'b1101;
        else              c = 4'b1100;
        return {c, (b && !s.rst), 1'b0, b, 16'(scnt[k])};
    endfunction

    task automatic cyc(input stim_t s);
        logic [22:0] e[2];
        #1;
        rst = s.rst; if_rs = s.rs; if_rt = s.rt; uses_rt = s.usesrt;
        is_md = s.ismd; mem_rd = s.memread; ex_rt = s.exrt;
        br_tk = s.br; md_st = s.mdst;
        e[0] = expect_out(0, s);
        e[1] = expect_out(1, s);
        expq0.push_back(e[0]);
        expq1.push_back(e[1]);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (s.rst) begin
                md_left[k] = 0;
                scnt[k] = 0;
            end else begin
                if (e[k][20] && scnt[k] < 65535) scnt[k] = scnt[k] + 1;
                if (md_left[k] > 0) md_left[k] = md_left[k] - 1;
                else if (s.mdst) md_left[k] = lat[k];
            end
        end
    endtask

    task automatic check(input string name, input logic [22:0] act,
                         input logic [22:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (expq0.size() > 0)
            check("lat4", {pc0, ifw0, bub0, fl0, busy0, st0, cnt0}, expq0.pop_front());
        if (expq1.size() > 0)
            check("lat1", {pc1, ifw1, bub1, fl1, busy1, st1, cnt1}, expq1.pop_front());
    end

    initial begin
        stim_t s;
        @(posedge clk);
        s = IDLE; s.rst = 1'b1;
        repeat (2) cyc(s);
        repeat (3) cyc(IDLE);
        // load-use on rs, then the bubble clears the load
        s = IDLE; s.memread = 1'b1; s.exrt = 5'd8; s.rs = 5'd8;
        cyc(s);
        cyc(IDLE);
        s = IDLE; s.memread = 1'b1; s.exrt = 5'd0; s.rs = 5'd0;
        cyc(s);
        s = IDLE; s.memread = 1'b1; s.exrt = 5'd8; s.rs = 5'd1; s.rt = 5'd8;
        cyc(s);
        s.usesrt = 1'b1;
        cyc(s);
        s = IDLE; s.br = 1'b1;
        cyc(s);
        s = IDLE; s.br = 1'b1; s.memread = 1'b1; s.exrt = 5'd8; s.rs = 5'd8;
        cyc(s);
        cyc(IDLE);
        // multi-cycle window with a dependent mult/div waiting in ID
        s = IDLE; s.mdst = 1'b1;
        cyc(s);
        s = IDLE; s.ismd = 1'b1;
        repeat (6) cyc(s);
        cyc(IDLE);
        // reset in the middle of the window
        s = IDLE; s.mdst = 1'b1;
        cyc(s);
        cyc(IDLE);
        s = IDLE; s.rst = 1'b1; s.ismd = 1'b1;
        cyc(s);
        s = IDLE; s.ismd = 1'b1;
        repeat (3) cyc(s);
        // back-to-back starts
        s = IDLE; s.mdst = 1'b1;
        repeat (3) cyc(s);
        repeat (6) cyc(IDLE);
        for (int i = 0; i < 3000; i++) begin
            s.rst     = ($urandom_range(63) == 0);
            s.rs      = 5'($urandom_range(3));
            s.rt      = 5'($urandom_range(3));
            s.exrt    = 5'($urandom_range(3));
            s.usesrt  = 1'($urandom_range(1));
            s.ismd    = 1'($urandom_range(1));
            s.memread = ($urandom_range(3) == 0);
            s.br      = ($urandom_range(3) == 0);
            s.mdst    = ($urandom_range(7) == 0);
            cyc(s);
        end
        // saturation of the bubble counter
        s = IDLE; s.rst = 1'b1;
        cyc(s);
        s = IDLE; s.memread = 1'b1; s.exrt = 5'd9; s.rs = 5'd9;
        repeat (65540) cyc(s);
        repeat (3) cyc(IDLE);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (expq0.size() != 0 || expq1.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d/%0d expected=0/0", expq0.size(), expq1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
